// File: rtl/mf_pkg.sv
// Shared definitions for the multifunction gate and its bit-serial driver.
// Op code constants and the driver FSM state type.
package mf_pkg;

  localparam logic [1:0] MF_OP_X  = 2'b00;
  localparam logic [1:0] MF_OP_Y0 = 2'b01;
  localparam logic [1:0] MF_OP_Y1 = 2'b10;
  localparam logic [1:0] MF_OP_NX = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } mf_state_e;

endpackage

// File: rtl/mfGate.sv
// Multifunction gate bit-slice: f = x, y, y or ~x selected by {a,b}.
// Ports: x, y data bits; a, b function select; f result bit.
module mfGate
  import mf_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic a,
  input  logic b,
  output logic f
);

  always_comb begin
    f = x;
    unique case ({a, b})
      MF_OP_X:  f = x;
      MF_OP_Y0: f = y;
      MF_OP_Y1: f = y;
      MF_OP_NX: f = ~x;
      default:  f = x;
    endcase
  end

endmodule

// File: rtl/mf_serial_driver.sv
// Bit-serial driver: accepts {x,y,op}, streams LSB-first through one mfGate,
// reassembles a W-bit result. Ports: clk, rst_n, in_valid/in_ready/in_x/in_y/
// in_op, out_valid/out_ready/out_data, busy; out_parity with MF_SERIAL_PARITY_EN.
module mf_serial_driver
  import mf_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
`ifdef MF_SERIAL_PARITY_EN
  ,output logic        out_parity
`endif
);

  localparam int CW = $clog2(W);

  mf_state_e      r_state;
  mf_state_e      w_next;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [W-1:0]   r_res;
  logic [1:0]     r_op;
  logic [CW-1:0]  r_cnt;
  logic           w_f;
  logic           w_last;
  logic           w_accept;
  logic [W-1:0]   w_res_nxt;

  mfGate u_gate (
    .x (r_x[0]),
    .y (r_y[0]),
    .a (r_op[1]),
    .b (r_op[0]),
    .f (w_f)
  );

  assign w_last    = (r_cnt == CW'(W - 1));
  assign w_accept  = (r_state == IDLE) && in_valid;
  // New bit enters at the MSB so the LSB-first stream lands in place.
  assign w_res_nxt = {w_f, r_res[W-1:1]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_x   <= in_x;
        r_y   <= in_y;
        r_op  <= in_op;
        r_cnt <= '0;
        r_res <= '0;
      end else if (r_state == SHIFT) begin
        r_x   <= r_x >> 1;
        r_y   <= r_y >> 1;
        r_res <= w_res_nxt;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef MF_SERIAL_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_par <= ^w_res_nxt;
    end
  end

  assign out_parity = r_par;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign out_data  = r_res;

endmodule

// File: tb/tb_mf_serial_driver.sv
// Self-checking bench for mf_serial_driver (W=8) against a word-level model.
// Directed steps plus random commands; parity checked with MF_SERIAL_PARITY_EN.
module tb_mf_serial_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic [1:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;
`ifdef MF_SERIAL_PARITY_EN
  logic         out_parity;
`endif

  int n_chk = 0;
  int n_fail = 0;

  mf_serial_driver #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef MF_SERIAL_PARITY_EN
    ,.out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Word-level reference: the op selects a whole-word function.
  function automatic logic [W-1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic [1:0] op);
    case (op)
      2'd0:    return x;
      2'd1:    return y;
      2'd2:    return y;
      default: return ~x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a negedge in IDLE.
  task automatic run_cmd(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [1:0] op, input string tag);
    logic [W-1:0] e;
    e = model(x, y, op);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_x = x; in_y = y; in_op = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_x = W'($urandom); in_y = W'($urandom); in_op = 2'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_nrdy"}, 32'(in_ready), 32'd0);
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      chk({tag, "_early"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(e));
`ifdef MF_SERIAL_PARITY_EN
    chk({tag, "_par"}, 32'(out_parity), 32'(^e));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    chk({tag, "_done"}, 32'(out_valid), 32'd0);
  endtask

  logic [W-1:0] held;
  logic [W-1:0] bx[3];
  logic [W-1:0] by[3];
  logic [1:0]   bo[3];
  logic [W-1:0] expq[$];
  int acc_cyc[3];
  int acc;
  int res;

  initial begin
    // Reset state
    #2;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
`ifdef MF_SERIAL_PARITY_EN
    chk("rst_par", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed op codes
    run_cmd(8'hA5, 8'h3C, 2'b00, "op00");
    run_cmd(8'hA5, 8'h3C, 2'b11, "op11");
    run_cmd(8'hA5, 8'h3C, 2'b01, "op01");
    run_cmd(8'hA5, 8'h3C, 2'b10, "op10");
    chk("lit_5a", 32'(model(8'hA5, 8'h3C, 2'b11)), 32'h5A);

    // Backpressure
    in_x = 8'h5A; in_y = 8'hC3; in_op = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W) @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    held = out_data;
    chk("bp_data", 32'(held), 32'h5A);
    in_x = 8'hFF; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", 32'(out_data), 32'(held));
      chk("bp_nrdy", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_vld", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_idle", 32'(in_ready), 32'd1);
    chk("bp_nbusy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("bp_noacc", 32'(busy), 32'd0);

    // Back-to-back with in_valid held high
    for (int j = 0; j < 3; j++) begin
      bx[j] = W'($urandom); by[j] = W'($urandom); bo[j] = 2'($urandom);
    end
    acc = 0; res = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60 && res < 3; c++) begin
      if (out_valid) begin
        chk("b2b_data", 32'(out_data), 32'(expq.pop_front()));
        res++;
      end
      if (in_ready) begin
        if (acc < 3) begin
          in_x = bx[acc]; in_y = by[acc]; in_op = bo[acc];
          expq.push_back(model(bx[acc], by[acc], bo[acc]));
          acc_cyc[acc] = c;
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_count", 32'(res), 32'd3);
    chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
    chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
    @(negedge clk);

    // Reset during SHIFT
    in_x = 8'h33; in_y = 8'h44; in_op = 2'b11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_vld", 32'(out_valid), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(8'h0F, 8'hF0, 2'b11, "mr_next");

`ifdef MF_SERIAL_PARITY_EN
    run_cmd(8'h07, 8'h00, 2'b00, "par07");
    chk("par07_lit", 32'(^model(8'h07, 8'h00, 2'b00)), 32'd1);
    run_cmd(8'hA5, 8'h00, 2'b00, "parA5");
`endif

    // Random commands
    for (int r = 0; r < 8; r++) begin
      run_cmd(W'($urandom), W'($urandom), 2'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
